// File: rtl/datapath_seq_pkg.sv
// Shared types and constants for the datapath sequencer: FSM states,
// instruction classes, opcode/ALU encodings and instruction field positions.
package datapath_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_GETA, S_GETB, S_COMP, S_WREG, S_WIMM, S_DONE, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    CLS_ILL, CLS_MOVI, CLS_MOVR, CLS_ALU
  } cls_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam int OPC_LO = 13;
  localparam int OP_LO  = 11;
  localparam int RN_LO  = 8;
  localparam int RD_LO  = 5;
  localparam int SH_LO  = 3;
  localparam int RM_LO  = 0;
  localparam int IMM8_W = 8;

endpackage

// File: rtl/datapath_sequencer_decode.sv
// Combinational field decoder: splits the latched instruction into its class,
// register numbers, shift code, ALU op and sign-extended 8-bit immediate.
module seq_decode
  import datapath_seq_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_W   = 3
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [1:0]         cls,
  output logic [REG_W-1:0]   rn,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rm,
  output logic [1:0]         sh,
  output logic [1:0]         op,
  output logic [INSTR_W-1:0] sximm8
);

  logic [2:0] w_opc;

  assign w_opc  = instr[OPC_LO +: 3];
  assign op     = instr[OP_LO +: 2];
  assign rn     = instr[RN_LO +: REG_W];
  assign rd     = instr[RD_LO +: REG_W];
  assign rm     = instr[RM_LO +: REG_W];
  assign sh     = instr[SH_LO +: 2];
  assign sximm8 = {{(INSTR_W-IMM8_W){instr[IMM8_W-1]}}, instr[IMM8_W-1:0]};

  always_comb begin
    cls = CLS_ILL;
    if (w_opc == OPC_MOV && op == OP_MOVI)      cls = CLS_MOVI;
    else if (w_opc == OPC_MOV && op == OP_MOVR) cls = CLS_MOVR;
    else if (w_opc == OPC_ALU)                  cls = CLS_ALU;
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Moore FSM driving every register-file/datapath strobe for one instruction.
// Optional DATAPATH_SEQ_ILLEGAL_TRAP_EN: illegal opcodes set sticky err and park in TRAP.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_W   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  output logic               busy,
  output logic               done,
  output logic [REG_W-1:0]   readnum,
  output logic [REG_W-1:0]   writenum,
  output logic               write,
  output logic               vsel,
  output logic               loada,
  output logic               loadb,
  output logic               asel,
  output logic               bsel,
  output logic               loadc,
  output logic               loads,
  output logic [1:0]         shift,
  output logic [1:0]         ALUop,
  output logic [INSTR_W-1:0] sximm8
`ifdef DATAPATH_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic               err
`endif
);

  state_t             r_state, w_next;
  logic [INSTR_W-1:0] r_instr;
  logic [1:0]         w_cls, w_sh, w_op;
  logic [REG_W-1:0]   w_rn, w_rd, w_rm;
  logic               w_is_alu, w_is_cmp, w_is_mvn;

  seq_decode #(.INSTR_W(INSTR_W), .REG_W(REG_W)) u_decode (
    .instr  (r_instr),
    .cls    (w_cls),
    .rn     (w_rn),
    .rd     (w_rd),
    .rm     (w_rm),
    .sh     (w_sh),
    .op     (w_op),
    .sximm8 (sximm8)
  );

  assign w_is_alu = (w_cls == CLS_ALU);
  assign w_is_cmp = w_is_alu && (w_op == ALU_SUB);
  assign w_is_mvn = w_is_alu && (w_op == ALU_MVN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_instr <= instr;
    end
  end

`ifdef DATAPATH_SEQ_ILLEGAL_TRAP_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      r_err <= 1'b0;
    else if (r_state == S_DECODE && w_cls == CLS_ILL) r_err <= 1'b1;
  end

  assign err = r_err;
`endif

  always_comb begin
    w_next   = r_state;
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    case (r_state)
      S_IDLE: if (start) w_next = S_DECODE;
      S_DECODE: begin
        case (w_cls)
          CLS_MOVI: w_next = S_WIMM;
          CLS_MOVR: w_next = S_GETB;
          CLS_ALU:  w_next = w_is_mvn ? S_GETB : S_GETA;
`ifdef DATAPATH_SEQ_ILLEGAL_TRAP_EN
          default:  w_next = S_TRAP;
`else
          default:  w_next = S_DONE;
`endif
        endcase
      end
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GETB;
      end
      S_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_COMP;
      end
      S_COMP: begin
        shift  = w_sh;
        loadc  = 1'b1;
        // MOVR passes shifted B through ADD with Ain forced to zero
        asel   = w_is_alu && !w_is_mvn;
        ALUop  = w_is_alu ? w_op : ALU_ADD;
        loads  = w_is_cmp;
        w_next = w_is_cmp ? S_DONE : S_WREG;
      end
      S_WREG: begin
        writenum = w_rd;
        write    = 1'b1;
        w_next   = S_DONE;
      end
      S_WIMM: begin
        writenum = w_rn;
        vsel     = 1'b1;
        write    = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end

endmodule
